// File: rtl/seg7_scan_ctrl_if.sv
// Signal bundle between a display source and the seven-segment scan controller.
// The source drives control and value inputs; the controller drives the pins.
interface seg7_scan_ctrl_if;
  logic        tick;
  logic        disp_en;
  logic        lz_en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        pending;
  logic        frame_done;

  modport master (
    output tick, disp_en, lz_en, load, value, dp_in,
    input  an, seg, dp_n, pending, frame_done
  );

  modport slave (
    input  tick, disp_en, lz_en, load, value, dp_in,
    output an, seg, dp_n, pending, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Basys-3 four-digit seven-segment scanner: one digit lit at a time with a blanking
// gap between digits, and a shadow value that is applied only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int BLANK_CYCLES = 16
) (
  input logic             clk,
  input logic             clr_n,
  seg7_scan_ctrl_if.slave bus
);

  typedef enum logic {BLANK, ON} state_t;

  localparam logic [7:0] GapLast = 8'(BLANK_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] active_q, active_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  dp_act_q, dp_act_d;
  logic [3:0]  dp_shadow_q, dp_shadow_d;
  logic        pending_q, pending_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_n_q, dp_n_d;
  logic        frame_done_q, frame_done_d;

  logic        apply;
  logic [3:0]  nibble;
  logic        upperZero;

  function automatic logic [6:0] hexToSeg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // upperZero: this digit and every more-significant digit are zero (digit 0 never blanks)
  always_comb begin
    nibble    = active_q[3:0];
    upperZero = 1'b0;
    case (idx_q)
      2'd0: begin
        nibble    = active_q[3:0];
        upperZero = 1'b0;
      end
      2'd1: begin
        nibble    = active_q[7:4];
        upperZero = (active_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble    = active_q[11:8];
        upperZero = (active_q[15:8] == 8'h00);
      end
      default: begin
        nibble    = active_q[15:12];
        upperZero = (active_q[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    dp_act_d     = dp_act_q;
    dp_shadow_d  = dp_shadow_q;
    pending_d    = pending_q;
    seg_d        = seg_q;
    dp_n_d       = dp_n_q;
    frame_done_d = 1'b0;
    apply        = 1'b0;
    an_d         = 4'b1111;

    if (state_q == ON && bus.disp_en) begin
      an_d = ~(4'b0001 << idx_q);
    end

    case (state_q)
      BLANK: begin
        seg_d  = (bus.lz_en && upperZero) ? 7'b1111111 : hexToSeg(nibble);
        dp_n_d = ~dp_act_q[idx_q];
        if (gap_q == GapLast) begin
          state_d = ON;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        if (bus.tick) begin
          state_d = BLANK;
          gap_d   = 8'd0;
          if (idx_q == 2'd3) begin
            idx_d        = 2'd0;
            frame_done_d = 1'b1;
            apply        = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
    endcase

    if (apply && pending_q) begin
      active_d  = shadow_q;
      dp_act_d  = dp_shadow_q;
      pending_d = 1'b0;
    end

    // A load coinciding with the frame boundary bypasses the shadow entirely
    if (bus.load) begin
      if (apply) begin
        active_d  = bus.value;
        dp_act_d  = bus.dp_in;
        pending_d = 1'b0;
      end else begin
        shadow_d    = bus.value;
        dp_shadow_d = bus.dp_in;
        pending_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q      <= BLANK;
      idx_q        <= 2'd0;
      gap_q        <= 8'd0;
      active_q     <= 16'h0000;
      shadow_q     <= 16'h0000;
      dp_act_q     <= 4'h0;
      dp_shadow_q  <= 4'h0;
      pending_q    <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      dp_act_q     <= dp_act_d;
      dp_shadow_q  <= dp_shadow_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;

endmodule
